// File: rtl/param_register_file.sv
// Parametrised register bank with per-register function unit, two read ports,
// optional registered outputs/write bypass, and a one-register-per-cycle flush engine.
module param_register_file #(
  parameter int WIDTH   = 32,
  parameter int NREGS   = 8,
  parameter int REG_OUT = 0,
  parameter int BYPASS  = 1,
  localparam int AW     = (NREGS > 1) ? $clog2(NREGS) : 1
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [WIDTH-1:0] I,
  input  logic [NREGS-1:0] RegSel,
  input  logic [2:0]       FunSel,
  input  logic [AW-1:0]    OutASel,
  input  logic [AW-1:0]    OutBSel,
  input  logic             Flush,
  output logic [WIDTH-1:0] OutA,
  output logic [WIDTH-1:0] OutB,
  output logic             Wrap,
  output logic             Busy
);

  localparam int H = WIDTH / 2;

  localparam logic [2:0] F_DEC    = 3'b000;
  localparam logic [2:0] F_INC    = 3'b001;
  localparam logic [2:0] F_LOAD   = 3'b010;
  localparam logic [2:0] F_CLEAR  = 3'b011;
  localparam logic [2:0] F_SHL    = 3'b100;
  localparam logic [2:0] F_SHR    = 3'b101;
  localparam logic [2:0] F_LOADLO = 3'b110;

  typedef enum logic {S_IDLE, S_SWEEP} state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [AW-1:0]    r_idx;
  logic [AW-1:0]    w_idx_nxt;
  logic [WIDTH-1:0] r_regs [NREGS];
  logic [WIDTH-1:0] w_new  [NREGS];
  logic [NREGS-1:0] w_wrapk;
  logic             r_wrap;
  logic             w_busy;
  logic [WIDTH-1:0] w_rd_a;
  logic [WIDTH-1:0] w_rd_b;

  function automatic logic [WIDTH-1:0] f_fun(input logic [2:0] f,
                                             input logic [WIDTH-1:0] q,
                                             input logic [WIDTH-1:0] d);
    case (f)
      F_DEC:    f_fun = q - WIDTH'(1);
      F_INC:    f_fun = q + WIDTH'(1);
      F_LOAD:   f_fun = d;
      F_CLEAR:  f_fun = '0;
      F_SHL:    f_fun = {q[WIDTH-2:0], 1'b0};
      F_SHR:    f_fun = {1'b0, q[WIDTH-1:1]};
      F_LOADLO: f_fun = {{H{1'b0}}, d[H-1:0]};
      default:  f_fun = {d[H-1:0], q[H-1:0]};
    endcase
  endfunction

  assign w_busy = (r_state == S_SWEEP);

  always_comb begin
    w_state_nxt = r_state;
    w_idx_nxt   = r_idx;
    case (r_state)
      S_IDLE: begin
        if (Flush) begin
          w_state_nxt = S_SWEEP;
          w_idx_nxt   = '0;
        end
      end
      S_SWEEP: begin
        if (r_idx == AW'(NREGS - 1)) begin
          w_state_nxt = S_IDLE;
          w_idx_nxt   = '0;
        end else begin
          w_idx_nxt = r_idx + AW'(1);
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_idx_nxt   = '0;
      end
    endcase
  end

  // Next value of every register: flush clear takes priority and locks out RegSel.
  always_comb begin
    w_wrapk = '0;
    for (int k = 0; k < NREGS; k++) begin
      w_new[k] = r_regs[k];
      if (w_busy) begin
        if (r_idx == AW'(k)) w_new[k] = '0;
      end else if (RegSel[k]) begin
        w_new[k]   = f_fun(FunSel, r_regs[k], I);
        w_wrapk[k] = ((FunSel == F_INC) && (&r_regs[k])) ||
                     ((FunSel == F_DEC) && (r_regs[k] == '0));
      end
    end
  end

  always_ff @(posedge Clock or posedge Reset) begin
    if (Reset) begin
      r_state <= S_IDLE;
      r_idx   <= '0;
      r_wrap  <= 1'b0;
      for (int k = 0; k < NREGS; k++) r_regs[k] <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_idx   <= w_idx_nxt;
      // Wrap never shows while the sweep runs, including its first cycle.
      r_wrap  <= (|w_wrapk) && (w_state_nxt == S_IDLE);
      for (int k = 0; k < NREGS; k++) r_regs[k] <= w_new[k];
    end
  end

  generate
    if (BYPASS != 0) begin : g_bypass
      assign w_rd_a = w_new[OutASel];
      assign w_rd_b = w_new[OutBSel];
    end else begin : g_direct
      assign w_rd_a = r_regs[OutASel];
      assign w_rd_b = r_regs[OutBSel];
    end

    if (REG_OUT != 0) begin : g_reg_out
      logic [WIDTH-1:0] r_out_a;
      logic [WIDTH-1:0] r_out_b;
      always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
          r_out_a <= '0;
          r_out_b <= '0;
        end else begin
          r_out_a <= w_rd_a;
          r_out_b <= w_rd_b;
        end
      end
      assign OutA = r_out_a;
      assign OutB = r_out_b;
    end else begin : g_comb_out
      assign OutA = w_rd_a;
      assign OutB = w_rd_b;
    end
  endgenerate

  assign Wrap = r_wrap;
  assign Busy = w_busy;

endmodule

// File: tb/tb_param_register_file.sv
// Bench: combinational/bypass instance and registered/no-bypass instance driven in parallel.
module tb_param_register_file;

  logic        clk;
  logic        rst;
  logic [31:0] din;
  logic [7:0]  rs;
  logic [2:0]  fs;
  logic [2:0]  asel;
  logic [2:0]  bsel;
  logic        flush;
  logic [31:0] a0, b0, a1, b1;
  logic        wrap0, busy0, wrap1, busy1;

  int n_chk = 0;
  int n_err = 0;

  param_register_file #(.WIDTH(32), .NREGS(8), .REG_OUT(0), .BYPASS(1)) dut0 (
    .Clock(clk), .Reset(rst), .I(din), .RegSel(rs), .FunSel(fs),
    .OutASel(asel), .OutBSel(bsel), .Flush(flush),
    .OutA(a0), .OutB(b0), .Wrap(wrap0), .Busy(busy0));

  param_register_file #(.WIDTH(32), .NREGS(8), .REG_OUT(1), .BYPASS(0)) dut1 (
    .Clock(clk), .Reset(rst), .I(din), .RegSel(rs), .FunSel(fs),
    .OutASel(asel), .OutBSel(bsel), .Flush(flush),
    .OutA(a1), .OutB(b1), .Wrap(wrap1), .Busy(busy1));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog timeout n_err=%0d n_chk=%0d", n_err, n_chk);
    $fatal(1);
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // a0/b0: bypassed combinational value before the edge; a1/b1: pre-write value captured at the edge.
  typedef struct {
    logic [7:0]  rs;
    logic [2:0]  fs;
    logic [31:0] d;
    logic [2:0]  as;
    logic [2:0]  bs;
    logic [31:0] a0;
    logic [31:0] b0;
    logic [31:0] a1;
    logic [31:0] b1;
    logic        wr;
  } vec_t;

  vec_t        tbl [16];
  logic [63:0] sb_q [$];
  logic [63:0] sb_e;
  int          cnt;

  initial begin
    tbl[0]  = '{8'h04, 3'd2, 32'hDEADBEEF, 3'd2, 3'd3, 32'hDEADBEEF, 32'h00000000, 32'h00000000, 32'h00000000, 1'b0};
    tbl[1]  = '{8'h00, 3'd2, 32'h00000000, 3'd2, 3'd0, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[2]  = '{8'h20, 3'd2, 32'hFFFFFFFF, 3'd5, 3'd2, 32'hFFFFFFFF, 32'hDEADBEEF, 32'h00000000, 32'hDEADBEEF, 1'b0};
    tbl[3]  = '{8'h20, 3'd1, 32'h00000000, 3'd5, 3'd5, 32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1};
    tbl[4]  = '{8'h20, 3'd0, 32'h00000000, 3'd5, 3'd5, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000, 32'h00000000, 1'b1};
    tbl[5]  = '{8'h20, 3'd2, 32'h00000005, 3'd5, 3'd5, 32'h00000005, 32'h00000005, 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b0};
    tbl[6]  = '{8'h20, 3'd1, 32'h00000000, 3'd5, 3'd5, 32'h00000006, 32'h00000006, 32'h00000005, 32'h00000005, 1'b0};
    tbl[7]  = '{8'h02, 3'd2, 32'h00000007, 3'd1, 3'd1, 32'h00000007, 32'h00000007, 32'h00000000, 32'h00000000, 1'b0};
    tbl[8]  = '{8'h02, 3'd1, 32'h00000000, 3'd1, 3'd1, 32'h00000008, 32'h00000008, 32'h00000007, 32'h00000007, 1'b0};
    tbl[9]  = '{8'hFF, 3'd6, 32'h1234ABCD, 3'd2, 3'd7, 32'h0000ABCD, 32'h0000ABCD, 32'hDEADBEEF, 32'h00000000, 1'b0};
    tbl[10] = '{8'hFF, 3'd7, 32'h00005678, 3'd0, 3'd5, 32'h5678ABCD, 32'h5678ABCD, 32'h0000ABCD, 32'h0000ABCD, 1'b0};
    tbl[11] = '{8'hFF, 3'd5, 32'h00000000, 3'd0, 3'd5, 32'h2B3C55E6, 32'h2B3C55E6, 32'h5678ABCD, 32'h5678ABCD, 1'b0};
    tbl[12] = '{8'h01, 3'd4, 32'h00000000, 3'd0, 3'd1, 32'h5678ABCC, 32'h2B3C55E6, 32'h2B3C55E6, 32'h2B3C55E6, 1'b0};
    tbl[13] = '{8'h02, 3'd3, 32'h00000000, 3'd1, 3'd0, 32'h00000000, 32'h5678ABCC, 32'h2B3C55E6, 32'h5678ABCC, 1'b0};
    tbl[14] = '{8'h03, 3'd0, 32'h00000000, 3'd0, 3'd1, 32'h5678ABCB, 32'hFFFFFFFF, 32'h5678ABCC, 32'h00000000, 1'b1};
    tbl[15] = '{8'h00, 3'd2, 32'h00000000, 3'd1, 3'd0, 32'hFFFFFFFF, 32'h5678ABCB, 32'hFFFFFFFF, 32'h5678ABCB, 1'b0};

    rst = 1'b1; din = '0; rs = '0; fs = 3'd2; asel = '0; bsel = '0; flush = 1'b0;
    #12;
    chk("reset_a0", a0, 32'h0);
    chk("reset_b0", b0, 32'h0);
    chk("reset_a1", a1, 32'h0);
    chk("reset_b1", b1, 32'h0);
    chk("reset_wrap", {31'h0, wrap0}, 32'h0);
    chk("reset_busy", {31'h0, busy0 | busy1}, 32'h0);
    @(negedge clk);
    rst = 1'b0;

    // Table: one transaction per cycle, registered-port expectations via scoreboard.
    for (int v = 0; v < 16; v++) begin
      @(negedge clk);
      rs = tbl[v].rs; fs = tbl[v].fs; din = tbl[v].d; asel = tbl[v].as; bsel = tbl[v].bs;
      sb_q.push_back({tbl[v].a1, tbl[v].b1});
      #2;
      chk($sformatf("v%0d_outa_byp", v), a0, tbl[v].a0);
      chk($sformatf("v%0d_outb_byp", v), b0, tbl[v].b0);
      @(posedge clk);
      #1;
      sb_e = sb_q.pop_front();
      chk($sformatf("v%0d_outa_reg", v), a1, sb_e[63:32]);
      chk($sformatf("v%0d_outb_reg", v), b1, sb_e[31:0]);
      chk($sformatf("v%0d_wrap", v), {31'h0, wrap0}, {31'h0, tbl[v].wr});
      chk($sformatf("v%0d_wrap_r", v), {31'h0, wrap1}, {31'h0, tbl[v].wr});
      chk($sformatf("v%0d_busy", v), {31'h0, busy0}, 32'h0);
    end

    // Flush sweep: fill bank, pulse Flush, then try to load during Busy.
    @(negedge clk);
    rs = 8'hFF; fs = 3'd2; din = 32'hA5A5A5A5;
    @(negedge clk);
    rs = 8'h00; flush = 1'b1;
    @(posedge clk);
    #1;
    chk("flush_busy_start", {31'h0, busy0}, 32'h1);
    for (int j = 0; j < 8; j++) begin
      @(negedge clk);
      flush = 1'b0; rs = 8'hFF; fs = 3'd2; din = 32'h12345678;
      asel = 3'(j); bsel = 3'((j + 1) % 8);
      #2;
      chk($sformatf("flush_clr_r%0d", j), a0, 32'h0);
      chk($sformatf("flush_next_r%0d", (j + 1) % 8), b0, (j < 7) ? 32'hA5A5A5A5 : 32'h0);
      @(posedge clk);
      #1;
      chk($sformatf("flush_busy_e%0d", j + 1), {31'h0, busy0}, (j < 7) ? 32'h1 : 32'h0);
    end
    @(negedge clk);
    rs = 8'h00;
    for (int k = 0; k < 8; k++) begin
      asel = 3'(k);
      #1;
      chk($sformatf("post_flush_r%0d", k), a0, 32'h0);
    end

    // Reset mid-sweep at idx=3.
    @(negedge clk);
    rs = 8'hFF; fs = 3'd2; din = 32'hA5A5A5A5;
    @(negedge clk);
    rs = 8'h00; flush = 1'b1;
    @(posedge clk);
    @(negedge clk);
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_busy", {31'h0, busy0}, 32'h0);
    chk("midrst_busy_r", {31'h0, busy1}, 32'h0);
    chk("midrst_outa_r", a1, 32'h0);
    for (int k = 0; k < 8; k++) begin
      asel = 3'(k);
      #0.5;
      chk($sformatf("midrst_r%0d", k), a0, 32'h0);
    end
    @(negedge clk);
    rst = 1'b0; flush = 1'b1;

    // Held Flush: 8 busy cycles, one idle cycle, then a new sweep.
    @(posedge clk);
    #1;
    chk("resweep_start", {31'h0, busy0}, 32'h1);
    cnt = 1;
    for (int t = 0; t < 20 && busy0; t++) begin
      @(posedge clk);
      #1;
      if (busy0) cnt++;
    end
    chk("resweep_len", 32'(cnt), 32'd8);
    chk("resweep_gap", {31'h0, busy0}, 32'h0);
    @(posedge clk);
    #1;
    chk("resweep_restart", {31'h0, busy0}, 32'h1);
    flush = 1'b0;
    for (int t = 0; t < 20 && busy0; t++) begin
      @(posedge clk);
      #1;
    end
    chk("resweep_end", {31'h0, busy0}, 32'h0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
